// File: rtl/cache_memory_sa_if.sv
// cache_memory_sa_if
// Bundles the access, refill, flush and write-back signals between the cache
// controller (master) and the set-associative storage array (slave).
// Optional feature macro: CACHE_WSTRB_EN adds the req_wstrb byte-enable signal.
// Signals:
//   req_valid/req_we/req_addr/req_wdata[/req_wstrb]  lookup and access request
//   refill_valid/refill_data                         block refill from memory
//   flush_req                                        start of a full flush
//   wb_ready                                         memory accepts write-back
//   hit/victim_dirty                                 combinational lookup results
//   rdata/done                                       registered access results
//   wb_valid/wb_block/wb_addr                        write-back / victim block
//   busy/flush_done                                  flush engine status
interface cache_memory_sa_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
);
  localparam int BLOCK_W = WORDS * WORD_W;

  logic               req_valid;
  logic               req_we;
  logic [ADDR_W-1:0]  req_addr;
  logic [WORD_W-1:0]  req_wdata;
`ifdef CACHE_WSTRB_EN
  logic [WORD_W/8-1:0] req_wstrb;
`endif
  logic               refill_valid;
  logic [BLOCK_W-1:0] refill_data;
  logic               flush_req;
  logic               wb_ready;
  logic               hit;
  logic               victim_dirty;
  logic [WORD_W-1:0]  rdata;
  logic               done;
  logic               wb_valid;
  logic [BLOCK_W-1:0] wb_block;
  logic [ADDR_W-1:0]  wb_addr;
  logic               busy;
  logic               flush_done;

  modport master (
`ifdef CACHE_WSTRB_EN
    output req_wstrb,
`endif
    output req_valid, req_we, req_addr, req_wdata, refill_valid, refill_data,
           flush_req, wb_ready,
    input  hit, victim_dirty, rdata, done, wb_valid, wb_block, wb_addr, busy,
           flush_done
  );

  modport slave (
`ifdef CACHE_WSTRB_EN
    input  req_wstrb,
`endif
    input  req_valid, req_we, req_addr, req_wdata, refill_valid, refill_data,
           flush_req, wb_ready,
    output hit, victim_dirty, rdata, done, wb_valid, wb_block, wb_addr, busy,
           flush_done
  );
endinterface

// File: rtl/cache_memory_sa.sv
// cache_memory_sa
// Set-associative cache storage: tags, valid/dirty bits, block data and a
// tree-PLRU per set. Single-cycle lookup, registered read/write hits, block
// refill into the replacement victim, victim reporting on a miss, and a
// sequential flush engine writing back every dirty line over wb_valid/wb_ready.
// Optional feature macro: CACHE_WSTRB_EN enables per-byte write strobes.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cache_memory_sa_if.slave (request, refill, flush, write-back signals)
//
// state  | meaning
// IDLE   | serving lookups, hits and refills
// SCAN   | flush: examining the line at the counter
// WAIT   | flush: dirty line presented on wb_*, waiting for wb_ready
module cache_memory_sa #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input logic             clk,
  input logic             rst,
  cache_memory_sa_if.slave bus
);
  localparam int BLOCK_W = WORDS * WORD_W;
  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int BOFF_W  = $clog2(WORD_W / 8);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W - BOFF_W;
  localparam int LVL     = $clog2(WAYS);
  localparam int WAY_W   = (WAYS > 1) ? LVL : 1;
  localparam int PLRU_W  = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} state_t;

  logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
  logic [BLOCK_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]    valid_q  [SETS];
  logic [WAYS-1:0]    dirty_q  [SETS];
  logic [PLRU_W-1:0]  plru_q   [SETS];

  state_t             state_q;
  logic               busy_q, wb_valid_q, done_q, flush_done_q;
  logic [WORD_W-1:0]  rdata_q;
  logic [IDX_W-1:0]   fl_set, fl_set_nx;
  logic [WAY_W-1:0]   fl_way, fl_way_nx;
  logic               fl_last, fl_line_dirty, line_done;

  // Tree nodes are heap-numbered from 1 (children 2n, 2n+1); bit n-1 set means
  // the node points at its upper child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int n = 1;
    for (int l = 0; l < LVL; l++) n = 2 * n + int'(bits[n-1]);
    return WAY_W'(n - WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
    logic [PLRU_W-1:0] r = bits;
    int n = int'(way) + WAYS;
    for (int l = 0; l < LVL; l++) begin
      r[(n >> 1) - 1] = ~n[0];
      n = n >> 1;
    end
    return r;
  endfunction

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               hit_any, inv_any;
  logic [WAY_W-1:0]   hit_way, inv_way, vic_way;
  logic [WORD_W-1:0]  rd_word, merged_word;
  logic [WORD_W/8-1:0] wstrb;
  logic               wr_dirty, idle, do_refill, do_hit;
  logic               unused_addr;

  assign req_tag     = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx     = bus.req_addr[BOFF_W+OFF_W +: IDX_W];
  assign req_off     = bus.req_addr[BOFF_W +: OFF_W];
  assign unused_addr = ^bus.req_addr;

`ifdef CACHE_WSTRB_EN
  assign wstrb = bus.req_wstrb;
`else
  assign wstrb = '1;
`endif
  assign wr_dirty = |wstrb;

  // Descending scan leaves the lowest-index match / invalid way selected.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    vic_way = inv_any ? inv_way : plru_victim(plru_q[req_idx]);
  end

  always_comb begin
    rd_word     = data_mem[req_idx][hit_way][int'(req_off)*WORD_W +: WORD_W];
    merged_word = rd_word;
    for (int b = 0; b < WORD_W / 8; b++)
      if (wstrb[b]) merged_word[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
  end

  assign idle      = (state_q == S_IDLE);
  assign do_refill = idle & bus.refill_valid;
  assign do_hit    = idle & ~bus.refill_valid & bus.req_valid & hit_any;

  assign fl_last       = (fl_set == IDX_W'(SETS - 1)) && (fl_way == WAY_W'(WAYS - 1));
  assign fl_way_nx     = (fl_way == WAY_W'(WAYS - 1)) ? '0 : fl_way + 1'b1;
  assign fl_set_nx     = (fl_way == WAY_W'(WAYS - 1)) ? fl_set + 1'b1 : fl_set;
  assign fl_line_dirty = valid_q[fl_set][fl_way] & dirty_q[fl_set][fl_way];
  assign line_done     = (state_q == S_SCAN && !fl_line_dirty) ||
                         (state_q == S_WAIT && bus.wb_ready);

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (do_refill) begin
      tag_mem[req_idx][vic_way]  <= req_tag;
      data_mem[req_idx][vic_way] <= bus.refill_data;
    end else if (do_hit && bus.req_we) begin
      data_mem[req_idx][hit_way][int'(req_off)*WORD_W +: WORD_W] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      flush_done_q <= 1'b0;
      rdata_q      <= '0;
      fl_set       <= '0;
      fl_way       <= '0;
    end else begin
      done_q       <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (do_refill) begin
            valid_q[req_idx][vic_way] <= 1'b1;
            dirty_q[req_idx][vic_way] <= 1'b0;
            plru_q[req_idx]           <= plru_touch(plru_q[req_idx], vic_way);
            done_q                    <= 1'b1;
          end else if (do_hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            done_q          <= 1'b1;
            if (!bus.req_we) rdata_q <= rd_word;
            else if (wr_dirty) dirty_q[req_idx][hit_way] <= 1'b1;
          end
          if (bus.flush_req) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            fl_set  <= '0;
            fl_way  <= '0;
          end
        end
        S_SCAN: begin
          if (fl_line_dirty) begin
            state_q    <= S_WAIT;
            wb_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.wb_ready) begin
            dirty_q[fl_set][fl_way] <= 1'b0;
            wb_valid_q              <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (line_done) begin
        if (fl_last) begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          flush_done_q <= 1'b1;
        end else begin
          state_q <= S_SCAN;
          fl_set  <= fl_set_nx;
          fl_way  <= fl_way_nx;
        end
      end
    end
  end

  assign bus.hit          = hit_any & ~busy_q;
  assign bus.victim_dirty = valid_q[req_idx][vic_way] & dirty_q[req_idx][vic_way];
  assign bus.rdata        = rdata_q;
  assign bus.done         = done_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.busy         = busy_q;
  assign bus.flush_done   = flush_done_q;
  // During a flush wb_* follow the flush counter, which cannot move in WAIT.
  assign bus.wb_block     = busy_q ? data_mem[fl_set][fl_way] : data_mem[req_idx][vic_way];
  assign bus.wb_addr      = busy_q ?
      {tag_mem[fl_set][fl_way], fl_set, {(OFF_W+BOFF_W){1'b0}}} :
      {tag_mem[req_idx][vic_way], req_idx, {(OFF_W+BOFF_W){1'b0}}};
endmodule
